fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the in-order pipeline, sitting alongside the ID stage. It keeps its own in-flight table of destination registers for the EX..WB stages, so the pipeline no longer has to feed per-stage destinations in. It selects the forwarding source per operand and detects load-use hazards, inserting bubbles itself. A non-forwarding mode replaces forwarding with stall-until-writeback.

---
 rtl/fwd_hazard_ctrl_pkg.sv | 31 +++
 rtl/fwd_hazard_ctrl_if.sv | 37 +++
 rtl/fwd_hazard_ctrl_src_match.sv | 45 ++++
 rtl/fwd_hazard_ctrl.sv | 97 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared definitions for the forwarding/hazard controller: select codes and
// the in-flight table entry layout.
package fwd_hazard_ctrl_pkg;

  localparam int SEL_RF  = 0;
  localparam int SEL_EX  = 1;
  localparam int SEL_MEM = 2;
  localparam int SEL_WB  = 3;

  // Widest register address a table entry can hold; narrower ids are zero-extended.
  localparam int MAX_REG_AW = 8;

  typedef struct packed {
    logic                  vld;
    logic                  wr;
    logic                  ld;
    logic [MAX_REG_AW-1:0] dest;
  } tbl_entry_t;

  function automatic tbl_entry_t make_entry(input logic vld, input logic wr,
                                            input logic ld,
                                            input logic [MAX_REG_AW-1:0] dest);
    tbl_entry_t e;
    e.vld  = vld;
    e.wr   = wr;
    e.ld   = ld;
    e.dest = dest;
    return e;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage view of the forwarding/hazard controller: instruction fields and
// pipeline controls in, operand selects and stall status out.
interface fwd_hazard_ctrl_if #(
  parameter int REG_AW = 3,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 16
);
  logic              fwd_en;
  logic              pipe_hold;
  logic              flush;
  logic              id_valid;
  logic [REG_AW-1:0] id_src1;
  logic [REG_AW-1:0] id_src2;
  logic              id_src1_used;
  logic              id_src2_used;
  logic              id_is_st;
  logic              id_is_ld;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_dest;
  logic [SEL_W-1:0]  fwd_op1_sel;
  logic [SEL_W-1:0]  fwd_op2_sel;
  logic [SEL_W-1:0]  fwd_st_sel;
  logic              stall_id;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output fwd_en, pipe_hold, flush, id_valid, id_src1, id_src2,
           id_src1_used, id_src2_used, id_is_st, id_is_ld, id_wr_en, id_dest,
    input  fwd_op1_sel, fwd_op2_sel, fwd_st_sel, stall_id, stall_cnt
  );

  modport slave (
    input  fwd_en, pipe_hold, flush, id_valid, id_src1, id_src2,
           id_src1_used, id_src2_used, id_is_st, id_is_ld, id_wr_en, id_dest,
    output fwd_op1_sel, fwd_op2_sel, fwd_st_sel, stall_id, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl_src_match.sv
// Priority match of one source register against the in-flight table: youngest
// producer wins; also reports load-not-ready and any pre-writeback match.
module fwd_src_match
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int LD_LAT  = 1,
  parameter int SEL_W   = 2,
  parameter int REG_AW  = 3
) (
  input  tbl_entry_t [NUM_STG:1] i_tbl,
  input  logic [REG_AW-1:0]      i_src,
  input  logic                   i_used,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_ld_haz,
  output logic                   o_pre_wb
);

  logic [NUM_STG:1] w_hit;

  always_comb begin
    w_hit = '0;
    for (int k = 1; k <= NUM_STG; k++) begin
      w_hit[k] = i_tbl[k].vld && i_tbl[k].wr && i_used && (i_src != '0) &&
                 (i_tbl[k].dest == MAX_REG_AW'(i_src));
    end
  end

  // NOTE: every output gets a default before the loop so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    o_sel    = SEL_W'(SEL_RF);
    o_ld_haz = 1'b0;
    o_pre_wb = 1'b0;
    // Oldest first, so the youngest hit overwrites and wins.
    for (int k = NUM_STG; k >= SEL_EX; k--) begin
      if (w_hit[k]) begin
        o_sel    = SEL_W'(k);
        o_ld_haz = i_tbl[k].ld && (k <= LD_LAT);
        if (k < NUM_STG) o_pre_wb = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller beside ID; tracks destinations of
// the EX..WB instructions itself and inserts bubbles when data is not ready.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int REG_AW  = 3,
  parameter int NUM_STG = 3,
  parameter int LD_LAT  = 1,
  parameter int SEL_W   = 2,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              rst,
  fwd_hazard_ctrl_if.slave bus
);

  tbl_entry_t [NUM_STG:1] r_tbl;
  logic [CNT_W-1:0]       r_stall_cnt;

  logic [SEL_W-1:0] w_sel1, w_sel2, w_src2_sel;
  logic [SEL_W-1:0] w_op1_sel, w_op2_sel, w_st_sel;
  logic             w_ld_haz1, w_ld_haz2, w_pre_wb1, w_pre_wb2;
  logic             w_stall;

  fwd_src_match #(
    .NUM_STG(NUM_STG), .LD_LAT(LD_LAT), .SEL_W(SEL_W), .REG_AW(REG_AW)
  ) u_match_src1 (
    .i_tbl   (r_tbl),
    .i_src   (bus.id_src1),
    .i_used  (bus.id_src1_used),
    .o_sel   (w_sel1),
    .o_ld_haz(w_ld_haz1),
    .o_pre_wb(w_pre_wb1)
  );

  fwd_src_match #(
    .NUM_STG(NUM_STG), .LD_LAT(LD_LAT), .SEL_W(SEL_W), .REG_AW(REG_AW)
  ) u_match_src2 (
    .i_tbl   (r_tbl),
    .i_src   (bus.id_src2),
    .i_used  (bus.id_src2_used),
    .o_sel   (w_sel2),
    .o_ld_haz(w_ld_haz2),
    .o_pre_wb(w_pre_wb2)
  );

  always_comb begin
    w_stall    = 1'b0;
    w_op1_sel  = SEL_W'(SEL_RF);
    w_src2_sel = SEL_W'(SEL_RF);
    w_op2_sel  = SEL_W'(SEL_RF);
    w_st_sel   = SEL_W'(SEL_RF);
    if (bus.id_valid && !bus.flush) begin
      if (bus.fwd_en) begin
        // A load still in flight cannot be forwarded: stall and read nothing.
        w_stall    = w_ld_haz1 || w_ld_haz2;
        w_op1_sel  = w_ld_haz1 ? SEL_W'(SEL_RF) : w_sel1;
        w_src2_sel = w_ld_haz2 ? SEL_W'(SEL_RF) : w_sel2;
      end else begin
        w_stall = w_pre_wb1 || w_pre_wb2;
      end
      if (bus.id_is_st) w_st_sel  = w_src2_sel;
      else              w_op2_sel = w_src2_sel;
    end
  end

  assign bus.fwd_op1_sel = w_op1_sel;
  assign bus.fwd_op2_sel = w_op2_sel;
  assign bus.fwd_st_sel  = w_st_sel;
  assign bus.stall_id    = w_stall;
  assign bus.stall_cnt   = r_stall_cnt;

  // NOTE: state updates use non-blocking assignments so the shift reads the
  // pre-edge table and the result does not depend on statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is reset as a whole (a few flops, not a RAM) because
      // a stale vld bit would fake a hazard after reset.
      r_tbl       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (bus.flush) begin
        r_tbl <= '0;
      end else if (!bus.pipe_hold) begin
        for (int k = NUM_STG; k >= 2; k--) r_tbl[k] <= r_tbl[k-1];
        if (bus.id_valid && !w_stall)
          r_tbl[1] <= make_entry(1'b1, bus.id_wr_en, bus.id_is_ld,
                                 MAX_REG_AW'(bus.id_dest));
        else
          r_tbl[1] <= '0;
      end
      if (w_stall && !bus.pipe_hold && !(&r_stall_cnt))
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl: a default instance plus a deep, narrow
// counter instance (NUM_STG=6, CNT_W=2) for saturation.
module tb_fwd_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fwd_hazard_ctrl_if #(.REG_AW(3), .SEL_W(2), .CNT_W(16)) bus ();
  fwd_hazard_ctrl_if #(.REG_AW(3), .SEL_W(3), .CNT_W(2))  bus_sat ();

  fwd_hazard_ctrl #(
    .REG_AW(3), .NUM_STG(3), .LD_LAT(1), .SEL_W(2), .CNT_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  fwd_hazard_ctrl #(
    .REG_AW(3), .NUM_STG(6), .LD_LAT(1), .SEL_W(3), .CNT_W(2)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .bus(bus_sat)
  );

  typedef struct packed {
    logic       v;
    logic [2:0] s1;
    logic       u1;
    logic [2:0] s2;
    logic       u2;
    logic       is_st;
    logic       is_ld;
    logic       wr;
    logic [2:0] dest;
  } instr_t;

  typedef struct packed {
    logic [2:0]  op1;
    logic [2:0]  op2;
    logic [2:0]  st;
    logic        stall;
    logic [15:0] cnt;
  } obs_t;

  typedef struct packed {
    logic   fwd_en;
    logic   hold;
    logic   flush;
    instr_t ins;
    obs_t   exp;
  } step_t;

  obs_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic instr_t f_nop();
    return '0;
  endfunction

  function automatic instr_t f_alu(input logic [2:0] d, input logic [2:0] a,
                                   input logic [2:0] b);
    instr_t i = '0;
    i.v = 1'b1; i.s1 = a; i.u1 = 1'b1; i.s2 = b; i.u2 = 1'b1;
    i.wr = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic instr_t f_ld(input logic [2:0] d, input logic [2:0] a);
    instr_t i = '0;
    i.v = 1'b1; i.s1 = a; i.u1 = 1'b1; i.is_ld = 1'b1; i.wr = 1'b1; i.dest = d;
    return i;
  endfunction

  function automatic instr_t f_sw(input logic [2:0] a, input logic [2:0] b);
    instr_t i = '0;
    i.v = 1'b1; i.s1 = a; i.u1 = 1'b1; i.s2 = b; i.u2 = 1'b1; i.is_st = 1'b1;
    return i;
  endfunction

  function automatic obs_t f_obs(input int op1, input int op2, input int st,
                                 input logic stall, input int cnt);
    obs_t o;
    o.op1 = 3'(op1); o.op2 = 3'(op2); o.st = 3'(st);
    o.stall = stall; o.cnt = 16'(cnt);
    return o;
  endfunction

  function automatic step_t mk(input logic fe, input logic hd, input logic fl,
                               input instr_t ins, input obs_t e);
    step_t s;
    s.fwd_en = fe; s.hold = hd; s.flush = fl; s.ins = ins; s.exp = e;
    return s;
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("op1=%0d op2=%0d st=%0d stall=%0b cnt=%0d",
                     o.op1, o.op2, o.st, o.stall, o.cnt);
  endfunction

  function automatic obs_t sample_main();
    obs_t o;
    o.op1 = {1'b0, bus.fwd_op1_sel};
    o.op2 = {1'b0, bus.fwd_op2_sel};
    o.st  = {1'b0, bus.fwd_st_sel};
    o.stall = bus.stall_id;
    o.cnt = bus.stall_cnt;
    return o;
  endfunction

  function automatic obs_t sample_sat();
    obs_t o;
    o.op1 = bus_sat.fwd_op1_sel;
    o.op2 = bus_sat.fwd_op2_sel;
    o.st  = bus_sat.fwd_st_sel;
    o.stall = bus_sat.stall_id;
    o.cnt = {14'd0, bus_sat.stall_cnt};
    return o;
  endfunction

  task automatic drive(input logic fe, input logic hd, input logic fl,
                       input instr_t ins);
    bus.fwd_en = fe;       bus_sat.fwd_en = fe;
    bus.pipe_hold = hd;    bus_sat.pipe_hold = hd;
    bus.flush = fl;        bus_sat.flush = fl;
    bus.id_valid = ins.v;  bus_sat.id_valid = ins.v;
    bus.id_src1 = ins.s1;  bus_sat.id_src1 = ins.s1;
    bus.id_src2 = ins.s2;  bus_sat.id_src2 = ins.s2;
    bus.id_src1_used = ins.u1;  bus_sat.id_src1_used = ins.u1;
    bus.id_src2_used = ins.u2;  bus_sat.id_src2_used = ins.u2;
    bus.id_is_st = ins.is_st;   bus_sat.id_is_st = ins.is_st;
    bus.id_is_ld = ins.is_ld;   bus_sat.id_is_ld = ins.is_ld;
    bus.id_wr_en = ins.wr;      bus_sat.id_wr_en = ins.wr;
    bus.id_dest = ins.dest;     bus_sat.id_dest = ins.dest;
  endtask

  task automatic do_reset(input logic hd);
    drive(1'b1, hd, 1'b0, f_nop());
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(1, 0, 0, f_alu(1, 3, 3), f_obs(0, 0, 0, 0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fwd_priority();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(1, 0, 0, f_alu(3, 1, 2), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(3, 1, 2), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(4, 3, 3), f_obs(1, 1, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(5, 3, 4), f_obs(2, 1, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(6, 3, 7), f_obs(3, 0, 0, 0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL fwd_priority step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_load_use();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(1, 0, 0, f_ld(2, 1),     f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(4, 2, 1), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(4, 2, 1), f_obs(2, 0, 0, 0, 1)));
    tbl.push_back(mk(1, 0, 0, f_ld(3, 1),     f_obs(0, 0, 0, 0, 1)));
    tbl.push_back(mk(1, 0, 0, f_alu(5, 4, 3), f_obs(2, 0, 0, 1, 1)));
    tbl.push_back(mk(1, 0, 0, f_alu(5, 4, 3), f_obs(3, 2, 0, 0, 2)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL load_use step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_store();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(1, 0, 0, f_alu(5, 1, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_nop(),        f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_nop(),        f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_sw(1, 5),     f_obs(0, 0, 3, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(0, 1, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_nop(),        f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_nop(),        f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_sw(0, 0),     f_obs(0, 0, 0, 0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL store step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_only();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(0, 0, 0, f_alu(6, 1, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 0, 2)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL stall_only step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_flush();
    step_t  tbl[$];
    obs_t   got, want;
    instr_t inv;
    inv   = f_alu(5, 4, 4);
    inv.v = 1'b0;
    do_reset(1'b0);
    tbl.push_back(mk(1, 0, 0, f_ld(2, 1),     f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 1, 0, f_alu(4, 2, 1), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 1, 0, f_alu(4, 2, 1), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 1, 0, f_alu(4, 2, 1), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(1, 1, 1, f_alu(4, 2, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(4, 2, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, inv,            f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(1, 0, 0, f_alu(6, 4, 4), f_obs(2, 2, 0, 0, 0)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_main(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL hold_flush step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_saturation();
    step_t tbl[$];
    obs_t  got, want;
    do_reset(1'b0);
    tbl.push_back(mk(0, 0, 0, f_alu(6, 1, 1), f_obs(0, 0, 0, 0, 0)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 0)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 1)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 2)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 3)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 1, 3)));
    tbl.push_back(mk(0, 0, 0, f_alu(7, 6, 2), f_obs(0, 0, 0, 0, 3)));
    foreach (tbl[i]) begin
      drive(tbl[i].fwd_en, tbl[i].hold, tbl[i].flush, tbl[i].ins);
      sb_q.push_back(tbl[i].exp);
      #1;
      got = sample_sat(); want = sb_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL saturation step %0d: got %s, want %s", i, fmt(got), fmt(want));
      end
      @(negedge clk);
    end

    // Reset while held must still empty both tables and zero both counters.
    do_reset(1'b1);
    drive(1'b1, 1'b0, 1'b0, f_alu(7, 6, 6));
    sb_q.push_back(f_obs(0, 0, 0, 0, 0));
    sb_q.push_back(f_obs(0, 0, 0, 0, 0));
    #1;
    got = sample_sat(); want = sb_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL post_reset_sat: got %s, want %s", fmt(got), fmt(want));
    end
    got = sample_main(); want = sb_q.pop_front(); n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL post_reset_main: got %s, want %s", fmt(got), fmt(want));
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, f_nop());
    @(negedge clk);
    test_reset();
    test_fwd_priority();
    test_load_use();
    test_store();
    test_stall_only();
    test_hold_flush();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
